// File: rtl/rv32_decode_stage_pkg.sv
// rtl/rv32_decode_stage_pkg.sv - shared RV32IM decode types, opcodes and mnemonic helpers
package rv32_decode_stage_pkg;

    typedef logic [31:0] RV32I_OPERAND_t;
    typedef logic [6:0]  RV32I_OPCODE_t;
    typedef logic [4:0]  RV32I_REGISTER_t;
    typedef logic [31:0] RV32I_IMM_t;

    typedef enum logic [5:0] {
        NULL, LUI, AUIPC, JAL, JALR,
        BEQ, BNE, BLT, BGE, BLTU, BGEU,
        LB, LH, LW, LBU, LHU, SB, SH, SW,
        ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI,
        ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND,
        ECALL, EBREAK,
        MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
    } RV32I_INSTRUCTION_MNEMONIC_t;

    localparam RV32I_OPCODE_t OPC_LUI    = 7'b0110111;
    localparam RV32I_OPCODE_t OPC_AUIPC  = 7'b0010111;
    localparam RV32I_OPCODE_t OPC_JAL    = 7'b1101111;
    localparam RV32I_OPCODE_t OPC_JALR   = 7'b1100111;
    localparam RV32I_OPCODE_t OPC_BRANCH = 7'b1100011;
    localparam RV32I_OPCODE_t OPC_LOAD   = 7'b0000011;
    localparam RV32I_OPCODE_t OPC_STORE  = 7'b0100011;
    localparam RV32I_OPCODE_t OPC_OPIMM  = 7'b0010011;
    localparam RV32I_OPCODE_t OPC_OP     = 7'b0110011;
    localparam RV32I_OPCODE_t OPC_SYSTEM = 7'b1110011;

    localparam logic [6:0] F7_BASE   = 7'h00;
    localparam logic [6:0] F7_ALT    = 7'h20;
    localparam logic [6:0] F7_MULDIV = 7'h01;

    localparam RV32I_OPERAND_t INSTR_ECALL  = 32'h0000_0073;
    localparam RV32I_OPERAND_t INSTR_EBREAK = 32'h0010_0073;

    typedef struct packed {
        RV32I_OPCODE_t               opcode;
        RV32I_INSTRUCTION_MNEMONIC_t mnemonic;
        RV32I_REGISTER_t             rs1;
        RV32I_REGISTER_t             rs2;
        RV32I_REGISTER_t             rd;
        RV32I_IMM_t                  imm;
        logic                        illegal;
    } DECODED_INSTR_t;

    localparam DECODED_INSTR_t DECODED_RESET = '{
        opcode: '0, mnemonic: NULL, rs1: '0, rs2: '0, rd: '0, imm: '0, illegal: 1'b0
    };

    typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_TWO} skid_state_t;

    function automatic RV32I_INSTRUCTION_MNEMONIC_t base_op(input logic [2:0] f3);
        case (f3)
            3'd0:    return ADD;
            3'd1:    return SLL;
            3'd2:    return SLT;
            3'd3:    return SLTU;
            3'd4:    return XOR;
            3'd5:    return SRL;
            3'd6:    return OR;
            default: return AND;
        endcase
    endfunction

    function automatic RV32I_INSTRUCTION_MNEMONIC_t muldiv_op(input logic [2:0] f3);
        case (f3)
            3'd0:    return MUL;
            3'd1:    return MULH;
            3'd2:    return MULHSU;
            3'd3:    return MULHU;
            3'd4:    return DIV;
            3'd5:    return DIVU;
            3'd6:    return REM;
            default: return REMU;
        endcase
    endfunction

endpackage

// File: rtl/rv32_decode_comb.sv
// rtl/rv32_decode_comb.sv - combinational RV32I(M) field extraction and legality check
module rv32_decode_comb
    import rv32_decode_stage_pkg::*;
#(
    parameter bit M_EXT  = 1'b1,
    parameter bit STRICT = 1'b1
) (
    input  RV32I_OPERAND_t instr_i,
    output DECODED_INSTR_t dec_o
);

    logic [2:0]                  f3;
    logic [6:0]                  f7;
    RV32I_IMM_t                  imm_i, imm_s, imm_b, imm_u, imm_j;
    RV32I_INSTRUCTION_MNEMONIC_t mn;
    logic                        ill;

    assign f3    = instr_i[14:12];
    assign f7    = instr_i[31:25];
    assign imm_i = {{20{instr_i[31]}}, instr_i[31:20]};
    assign imm_s = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
    assign imm_b = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
    assign imm_u = {instr_i[31:12], 12'b0};
    assign imm_j = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};

    always_comb begin
        dec_o        = DECODED_RESET;
        dec_o.opcode = instr_i[6:0];
        mn           = NULL;
        ill          = 1'b0;
        case (instr_i[6:0])
            OPC_LUI, OPC_AUIPC: begin
                dec_o.rd  = instr_i[11:7];
                dec_o.imm = imm_u;
                mn        = (instr_i[6:0] == OPC_LUI) ? LUI : AUIPC;
            end
            OPC_JAL: begin
                dec_o.rd  = instr_i[11:7];
                dec_o.imm = imm_j;
                mn        = JAL;
            end
            OPC_JALR: begin
                dec_o.rd  = instr_i[11:7];
                dec_o.rs1 = instr_i[19:15];
                dec_o.imm = imm_i;
                mn        = JALR;
                ill       = STRICT && (f3 != 3'd0);
            end
            OPC_BRANCH: begin
                dec_o.rs1 = instr_i[19:15];
                dec_o.rs2 = instr_i[24:20];
                dec_o.imm = imm_b;
                case (f3)
                    3'd0:    mn = BEQ;
                    3'd1:    mn = BNE;
                    3'd4:    mn = BLT;
                    3'd5:    mn = BGE;
                    3'd6:    mn = BLTU;
                    3'd7:    mn = BGEU;
                    default: ill = 1'b1;
                endcase
            end
            OPC_LOAD: begin
                dec_o.rd  = instr_i[11:7];
                dec_o.rs1 = instr_i[19:15];
                dec_o.imm = imm_i;
                case (f3)
                    3'd0:    mn = LB;
                    3'd1:    mn = LH;
                    3'd2:    mn = LW;
                    3'd4:    mn = LBU;
                    3'd5:    mn = LHU;
                    default: ill = 1'b1;
                endcase
            end
            OPC_STORE: begin
                dec_o.rs1 = instr_i[19:15];
                dec_o.rs2 = instr_i[24:20];
                dec_o.imm = imm_s;
                case (f3)
                    3'd0:    mn = SB;
                    3'd1:    mn = SH;
                    3'd2:    mn = SW;
                    default: ill = 1'b1;
                endcase
            end
            OPC_OPIMM: begin
                dec_o.rd  = instr_i[11:7];
                dec_o.rs1 = instr_i[19:15];
                dec_o.imm = imm_i;
                case (f3)
                    3'd0: mn = ADDI;
                    3'd1: begin
                        mn  = SLLI;
                        ill = STRICT && (f7 != F7_BASE);
                    end
                    3'd2: mn = SLTI;
                    3'd3: mn = SLTIU;
                    3'd4: mn = XORI;
                    3'd5: begin
                        mn  = instr_i[30] ? SRAI : SRLI;
                        ill = STRICT && (f7 != F7_BASE) && (f7 != F7_ALT);
                    end
                    3'd6: mn = ORI;
                    default: mn = ANDI;
                endcase
            end
            OPC_OP: begin
                dec_o.rd  = instr_i[11:7];
                dec_o.rs1 = instr_i[19:15];
                dec_o.rs2 = instr_i[24:20];
                if (f7 == F7_MULDIV) begin
                    mn  = muldiv_op(f3);
                    ill = !M_EXT;
                end else begin
                    // Non-strict mode lets bit 30 pick the alternate op where one exists.
                    if (f7[5] && f3 == 3'd0)      mn = SUB;
                    else if (f7[5] && f3 == 3'd5) mn = SRA;
                    else                          mn = base_op(f3);
                    ill = STRICT && (f7 != F7_BASE) &&
                          !((f7 == F7_ALT) && (f3 == 3'd0 || f3 == 3'd5));
                end
            end
            OPC_SYSTEM: begin
                dec_o.rd  = instr_i[11:7];
                dec_o.rs1 = instr_i[19:15];
                dec_o.imm = imm_i;
                mn        = instr_i[20] ? EBREAK : ECALL;
                ill       = STRICT && (instr_i != INSTR_ECALL) && (instr_i != INSTR_EBREAK);
            end
            default: ill = 1'b1;
        endcase
        dec_o.illegal  = ill;
        dec_o.mnemonic = ill ? NULL : mn;
    end

endmodule

// File: rtl/rv32_decode_stage.sv
// rtl/rv32_decode_stage.sv - registered decode stage with 2-entry skid buffer and flush
module rv32_decode_stage
    import rv32_decode_stage_pkg::*;
#(
    parameter int PC_WIDTH = 32,
    parameter bit M_EXT    = 1'b1,
    parameter bit STRICT   = 1'b1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  RV32I_OPERAND_t              in_instr,
    input  logic [PC_WIDTH-1:0]         in_pc,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [PC_WIDTH-1:0]         out_pc,
    output RV32I_OPCODE_t               out_opcode,
    output RV32I_INSTRUCTION_MNEMONIC_t out_mnemonic,
    output RV32I_REGISTER_t             out_rs1,
    output RV32I_REGISTER_t             out_rs2,
    output RV32I_REGISTER_t             out_rd,
    output RV32I_IMM_t                  out_imm,
    output logic                        out_illegal
);

    DECODED_INSTR_t      in_dec;
    DECODED_INSTR_t      o_dec_q, s_dec_q;
    logic [PC_WIDTH-1:0] o_pc_q, s_pc_q;
    skid_state_t         state_q, state_d;
    logic                in_ready_q;
    logic                push, pop;
    logic                load_o_in, load_o_skid, load_skid;

    rv32_decode_comb #(
        .M_EXT  (M_EXT),
        .STRICT (STRICT)
    ) u_decode (
        .instr_i (in_instr),
        .dec_o   (in_dec)
    );

    assign push = in_valid && in_ready_q;
    assign pop  = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != ST_TWO);
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: if (push) state_d = ST_ONE;
                ST_ONE: begin
                    if (push && !pop)      state_d = ST_TWO;
                    else if (!push && pop) state_d = ST_EMPTY;
                end
                ST_TWO:   if (pop) state_d = ST_ONE;
                default:  state_d = ST_EMPTY;
            endcase
        end
    end

    always_comb begin
        out_valid   = (state_q != ST_EMPTY);
        load_o_in   = !flush && push && ((state_q == ST_EMPTY) || (state_q == ST_ONE && pop));
        load_skid   = !flush && push && (state_q == ST_ONE) && !pop;
        load_o_skid = !flush && pop && (state_q == ST_TWO);
    end

    // O is left untouched by flush; out_valid already tells the consumer to ignore it.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_dec_q <= DECODED_RESET;
            s_dec_q <= DECODED_RESET;
            o_pc_q  <= '0;
            s_pc_q  <= '0;
        end else begin
            if (load_o_in) begin
                o_dec_q <= in_dec;
                o_pc_q  <= in_pc;
            end else if (load_o_skid) begin
                o_dec_q <= s_dec_q;
                o_pc_q  <= s_pc_q;
            end
            if (load_skid) begin
                s_dec_q <= in_dec;
                s_pc_q  <= in_pc;
            end
        end
    end

    assign in_ready     = in_ready_q;
    assign out_pc       = o_pc_q;
    assign out_opcode   = o_dec_q.opcode;
    assign out_mnemonic = o_dec_q.mnemonic;
    assign out_rs1      = o_dec_q.rs1;
    assign out_rs2      = o_dec_q.rs2;
    assign out_rd       = o_dec_q.rd;
    assign out_imm      = o_dec_q.imm;
    assign out_illegal  = o_dec_q.illegal;

endmodule

// File: tb/tb_rv32_decode_stage.sv
// tb/tb_rv32_decode_stage.sv - directed bench for rv32_decode_stage (M_EXT=1 and M_EXT=0 instances)
module tb_rv32_decode_stage;
    import rv32_decode_stage_pkg::*;

    logic                        clk = 1'b0;
    logic                        rst, flush, in_valid, out_ready;
    RV32I_OPERAND_t              in_instr;
    logic [31:0]                 in_pc;

    logic                        in_ready, out_valid, out_illegal;
    logic [31:0]                 out_pc;
    RV32I_OPCODE_t               out_opcode;
    RV32I_INSTRUCTION_MNEMONIC_t out_mnemonic;
    RV32I_REGISTER_t             out_rs1, out_rs2, out_rd;
    RV32I_IMM_t                  out_imm;

    logic                        in_ready_n, out_valid_n, out_illegal_n;
    logic [31:0]                 out_pc_n;
    RV32I_OPCODE_t               out_opcode_n;
    RV32I_INSTRUCTION_MNEMONIC_t out_mnemonic_n;
    RV32I_REGISTER_t             out_rs1_n, out_rs2_n, out_rd_n;
    RV32I_IMM_t                  out_imm_n;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    rv32_decode_stage #(.PC_WIDTH(32), .M_EXT(1'b1), .STRICT(1'b1)) u_dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_opcode(out_opcode), .out_mnemonic(out_mnemonic),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd), .out_imm(out_imm),
        .out_illegal(out_illegal)
    );

    rv32_decode_stage #(.PC_WIDTH(32), .M_EXT(1'b0), .STRICT(1'b1)) u_nom (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_n),
        .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid_n), .out_ready(out_ready),
        .out_pc(out_pc_n), .out_opcode(out_opcode_n), .out_mnemonic(out_mnemonic_n),
        .out_rs1(out_rs1_n), .out_rs2(out_rs2_n), .out_rd(out_rd_n), .out_imm(out_imm_n),
        .out_illegal(out_illegal_n)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_dec(input string tag, input RV32I_INSTRUCTION_MNEMONIC_t mn,
                           input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [31:0] imm, input logic ill);
        chk({tag, ".valid"}, 32'(out_valid), 32'd1);
        chk({tag, ".mnem"}, 32'(out_mnemonic), 32'(mn));
        chk({tag, ".rd"}, 32'(out_rd), 32'(rd));
        chk({tag, ".rs1"}, 32'(out_rs1), 32'(rs1));
        chk({tag, ".rs2"}, 32'(out_rs2), 32'(rs2));
        chk({tag, ".imm"}, out_imm, imm);
        chk({tag, ".illegal"}, 32'(out_illegal), 32'(ill));
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".valid"}, 32'(out_valid), 32'd0);
        chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
        chk({tag, ".pc"}, out_pc, 32'd0);
        chk({tag, ".opcode"}, 32'(out_opcode), 32'd0);
        chk({tag, ".mnem"}, 32'(out_mnemonic), 32'(NULL));
        chk({tag, ".rd"}, 32'(out_rd), 32'd0);
        chk({tag, ".rs1"}, 32'(out_rs1), 32'd0);
        chk({tag, ".rs2"}, 32'(out_rs2), 32'd0);
        chk({tag, ".imm"}, out_imm, 32'd0);
        chk({tag, ".illegal"}, 32'(out_illegal), 32'd0);
    endtask

    task automatic send(input logic [31:0] instr, input logic [31:0] pc);
        in_valid = 1'b1;
        in_instr = instr;
        in_pc    = pc;
        tick();
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_instr = '0; in_pc = '0;
        tick(); tick();
        chk_reset("reset");
        rst = 1'b0;

        send(32'h0050_0093, 32'h100);
        chk_dec("addi", ADDI, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0);
        chk("addi.pc", out_pc, 32'h100);
        chk("addi.in_ready", 32'(in_ready), 32'd1);
        chk("addi.opcode", 32'(out_opcode), 32'h13);

        send(32'h0020_81B3, 32'h104);
        chk_dec("add", ADD, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0);
        chk("add.pc", out_pc, 32'h104);
        send(32'h4020_81B3, 32'h108);
        chk_dec("sub", SUB, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0);
        send(32'h0220_81B3, 32'h10C);
        chk_dec("mul", MUL, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0);
        chk("mul.nom.illegal", 32'(out_illegal_n), 32'd1);
        chk("mul.nom.mnem", 32'(out_mnemonic_n), 32'(NULL));
        send(32'h0220_C1B3, 32'h110);
        chk_dec("div", DIV, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0);
        chk("div.nom.illegal", 32'(out_illegal_n), 32'd1);
        chk("div.nom.mnem", 32'(out_mnemonic_n), 32'(NULL));

        send(32'h0020_8463, 32'h114);
        chk_dec("beq", BEQ, 5'd0, 5'd1, 5'd2, 32'd8, 1'b0);
        send(32'hFFDF_F0EF, 32'h118);
        chk_dec("jal", JAL, 5'd1, 5'd0, 5'd0, 32'hFFFF_FFFC, 1'b0);
        send(32'h1234_52B7, 32'h11C);
        chk_dec("lui", LUI, 5'd5, 5'd0, 5'd0, 32'h1234_5000, 1'b0);

        send(32'h0000_0073, 32'h120);
        chk_dec("ecall", ECALL, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0);
        send(32'h0010_0073, 32'h124);
        chk_dec("ebreak", EBREAK, 5'd0, 5'd0, 5'd0, 32'd1, 1'b0);
        send(32'h0020_0073, 32'h128);
        chk_dec("sys_rsvd", NULL, 5'd0, 5'd0, 5'd0, 32'd2, 1'b1);
        send(32'h6020_D193, 32'h12C);
        chk_dec("srai_f7_30", NULL, 5'd3, 5'd1, 5'd0, 32'h602, 1'b1);
        send(32'h0000_007F, 32'h130);
        chk_dec("unknown_opc", NULL, 5'd0, 5'd0, 5'd0, 32'd0, 1'b1);
        send(32'h0000_B003, 32'h134);
        chk_dec("load_f3_3", NULL, 5'd0, 5'd1, 5'd0, 32'd0, 1'b1);

        in_valid = 1'b0;
        tick();
        chk("drain.valid", 32'(out_valid), 32'd0);

        // Stall: three offered with out_ready low, only two fit.
        out_ready = 1'b0;
        send(32'h0010_0093, 32'h200);
        chk("stall1.in_ready", 32'(in_ready), 32'd1);
        chk("stall1.pc", out_pc, 32'h200);
        send(32'h0020_0113, 32'h204);
        chk("stall2.in_ready", 32'(in_ready), 32'd0);
        chk("stall2.pc", out_pc, 32'h200);
        send(32'h0030_0193, 32'h208);
        chk("stall3.in_ready", 32'(in_ready), 32'd0);
        chk("stall3.pc", out_pc, 32'h200);
        chk("stall3.imm", out_imm, 32'd1);
        out_ready = 1'b1;
        tick();
        chk("rel1.pc", out_pc, 32'h204);
        chk("rel1.imm", out_imm, 32'd2);
        chk("rel1.in_ready", 32'(in_ready), 32'd1);
        tick();
        chk("rel2.pc", out_pc, 32'h208);
        chk("rel2.rd", 32'(out_rd), 32'd3);
        chk("rel2.valid", 32'(out_valid), 32'd1);
        in_valid = 1'b0;
        tick();
        chk("rel3.valid", 32'(out_valid), 32'd0);

        // Flush while full with a new instruction offered.
        out_ready = 1'b0;
        send(32'h0040_0213, 32'h300);
        send(32'h0050_0293, 32'h304);
        chk("fl_pre.in_ready", 32'(in_ready), 32'd0);
        flush = 1'b1;
        send(32'h0060_0313, 32'h308);
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush.valid", 32'(out_valid), 32'd0);
        chk("flush.in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        tick();
        chk("flush_after.valid", 32'(out_valid), 32'd0);
        send(32'h0070_0393, 32'h400);
        chk("post_flush.pc", out_pc, 32'h400);
        chk("post_flush.imm", out_imm, 32'd7);
        in_valid = 1'b0;
        tick();
        chk("post_flush.drain", 32'(out_valid), 32'd0);

        // Reset while full; reset also wins over a concurrent flush.
        out_ready = 1'b0;
        send(32'h0040_0213, 32'h500);
        send(32'h0050_0293, 32'h504);
        rst = 1'b1;
        flush = 1'b1;
        send(32'h0060_0313, 32'h508);
        rst = 1'b0;
        flush = 1'b0;
        in_valid = 1'b0;
        chk_reset("midrst");
        out_ready = 1'b1;
        tick();
        chk("midrst_after.valid", 32'(out_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
